// File: rtl/jk_excite_gen.sv
// rtl/jk_excite_gen.sv - command-driven J/K excitation generator for a W-bit JK bank
// Tracks the bank state in a shadow register so J/K drives can be derived per cycle.
module jk_excite_gen #(
  parameter int W       = 4,
  parameter bit MIN_EXC = 1'b1
) (
  input  logic         clk,
  input  logic         cl,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  logic [W-1:0] cmd_data,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  output logic         jk_valid,
  output logic         busy,
  output logic [W-1:0] shadow
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   shadow_q, shadow_d;
  logic [W-1:0]   target_q, target_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   j_q, j_d;
  logic [W-1:0]   k_q, k_d;
  logic           vld_q, vld_d;
  logic [W-1:0]   shadow_inc;
  logic [W-1:0]   shadow_inc2;

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    j_d         = '0;
    k_d         = '0;
    vld_d       = 1'b0;
    shadow_inc  = shadow_q + W'(1);
    shadow_inc2 = shadow_q + W'(2);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (!cmd_op) begin
            target_d = cmd_data;
            state_d  = S_LOAD;
            vld_d    = 1'b1;
            if (MIN_EXC) begin
              j_d = cmd_data & ~shadow_q;
              k_d = ~cmd_data & shadow_q;
            end else begin
              j_d = cmd_data;
              k_d = ~cmd_data;
            end
          end else if (cmd_data != '0) begin
            // The first toggle mask is driven straight from the accept edge.
            cnt_d   = cmd_data;
            state_d = S_COUNT;
            vld_d   = 1'b1;
            j_d     = shadow_q ^ shadow_inc;
            k_d     = shadow_q ^ shadow_inc;
          end
        end
      end

      S_LOAD: begin
        shadow_d = target_q;
        state_d  = S_IDLE;
      end

      S_COUNT: begin
        shadow_d = shadow_inc;
        cnt_d    = cnt_q - W'(1);
        if (cnt_q == W'(1)) begin
          state_d = S_IDLE;
        end else begin
          // Next mask is taken against the value shadow holds after this edge.
          vld_d = 1'b1;
          j_d   = shadow_inc ^ shadow_inc2;
          k_d   = shadow_inc ^ shadow_inc2;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cl) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      vld_q    <= vld_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign j         = j_q;
  assign k         = k_q;
  assign jk_valid  = vld_q;
  assign shadow    = shadow_q;

endmodule

// File: tb/tb_jk_excite_gen.sv
// tb/tb_jk_excite_gen.sv - randomized and directed checks of jk_excite_gen against a queue model
// Two instances (minimal and forced load policy) share all inputs.
module tb_jk_excite_gen;

  logic       clk = 1'b0;
  logic       cl = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_op = 1'b0;
  logic [3:0] cmd_data = 4'h0;

  logic       rdy1, busy1, v1, rdy0, busy0, v0;
  logic [3:0] j1, k1, sh1, j0, k0, sh0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_excite_gen #(.W(4), .MIN_EXC(1'b1)) dut_min (
    .clk(clk), .cl(cl), .cmd_valid(cmd_valid), .cmd_ready(rdy1), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .j(j1), .k(k1), .jk_valid(v1), .busy(busy1), .shadow(sh1)
  );

  jk_excite_gen #(.W(4), .MIN_EXC(1'b0)) dut_frc (
    .clk(clk), .cl(cl), .cmd_valid(cmd_valid), .cmd_ready(rdy0), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .j(j0), .k(k0), .jk_valid(v0), .busy(busy0), .shadow(sh0)
  );

  // Model: a queue of pending drive cycles; each entry is applied at the edge ending its cycle.
  typedef struct {
    logic [3:0] j1, k1, j0, k0, nxt;
  } ent_t;

  ent_t       q[$];
  logic [3:0] m_sh = 4'h0;
  bit         model_ok = 1'b0;

  always @(posedge clk) begin
    ent_t       e;
    logic [3:0] s;
    if (cl) begin
      q.delete();
      m_sh     = 4'h0;
      model_ok = 1'b1;
    end else if (q.size() != 0) begin
      m_sh = q[0].nxt;
      void'(q.pop_front());
    end else if (cmd_valid) begin
      if (!cmd_op) begin
        e.j1  = cmd_data & ~m_sh;
        e.k1  = ~cmd_data & m_sh;
        e.j0  = cmd_data;
        e.k0  = ~cmd_data;
        e.nxt = cmd_data;
        q.push_back(e);
      end else begin
        s = m_sh;
        for (int i = 0; i < int'(cmd_data); i++) begin
          e.j1  = s ^ (s + 4'd1);
          e.k1  = e.j1;
          e.j0  = e.j1;
          e.k0  = e.j1;
          e.nxt = s + 4'd1;
          q.push_back(e);
          s = s + 4'd1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] ej1, ek1, ej0, ek0;
    logic       ev;
    if (model_ok) begin
      ev  = (q.size() != 0);
      ej1 = ev ? q[0].j1 : 4'h0;
      ek1 = ev ? q[0].k1 : 4'h0;
      ej0 = ev ? q[0].j0 : 4'h0;
      ek0 = ev ? q[0].k0 : 4'h0;
      chk("min_jk_valid", {3'b0, v1}, {3'b0, ev});
      chk("min_ready", {3'b0, rdy1}, {3'b0, !ev});
      chk("min_busy", {3'b0, busy1}, {3'b0, ev});
      chk("min_j", j1, ej1);
      chk("min_k", k1, ek1);
      chk("min_shadow", sh1, m_sh);
      chk("frc_jk_valid", {3'b0, v0}, {3'b0, ev});
      chk("frc_ready", {3'b0, rdy0}, {3'b0, !ev});
      chk("frc_busy", {3'b0, busy0}, {3'b0, ev});
      chk("frc_j", j0, ej0);
      chk("frc_k", k0, ek0);
      chk("frc_shadow", sh0, m_sh);
    end
  end

  // Returns at the falling edge of the first cycle after the accept edge.
  task automatic send(input logic op, input logic [3:0] d);
    int t = 0;
    @(negedge clk);
    while (!rdy1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=busy required=ready t=%0t", $time);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 1'($urandom);
    cmd_data  = 4'($urandom);
  endtask

  initial begin
    // Reset held two cycles with a LOAD presented
    cl = 1'b1; cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_shadow", sh1, 4'h0);
    chk("rst_valid", {3'b0, v1}, 4'h0);
    chk("rst_j", j1, 4'h0);
    chk("rst_k", k1, 4'h0);
    chk("rst_ready", {3'b0, rdy1}, 4'h1);
    cl = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_no_accept", sh1, 4'h0);

    send(1'b0, 4'h3);
    chk("load3_j", j1, 4'h3);
    send(1'b0, 4'h5);
    chk("load5_min_j", j1, 4'h4);
    chk("load5_min_k", k1, 4'h2);
    chk("load5_frc_j", j0, 4'h5);
    chk("load5_frc_k", k0, 4'hA);
    chk("load5_ready", {3'b0, rdy1}, 4'h0);
    @(negedge clk);
    chk("load5_shadow", sh1, 4'h5);
    chk("load5_ready_back", {3'b0, rdy1}, 4'h1);
    send(1'b0, 4'h5);
    chk("reload_min_j", j1, 4'h0);
    chk("reload_min_k", k1, 4'h0);
    chk("reload_frc_j", j0, 4'h5);

    send(1'b0, 4'hE);
    send(1'b1, 4'd3);
    chk("cnt_m1", j1, 4'h1);
    chk("cnt_sh1", sh1, 4'hE);
    chk("cnt_busy1", {3'b0, rdy1}, 4'h0);
    @(negedge clk);
    chk("cnt_m2", k1, 4'hF);
    chk("cnt_sh2", sh1, 4'hF);
    @(negedge clk);
    chk("cnt_m3", j1, 4'h1);
    chk("cnt_sh3", sh1, 4'h0);
    @(negedge clk);
    chk("cnt_done_valid", {3'b0, v1}, 4'h0);
    chk("cnt_done_ready", {3'b0, rdy1}, 4'h1);
    chk("cnt_done_sh", sh1, 4'h1);

    send(1'b1, 4'd0);
    chk("cnt0_valid", {3'b0, v1}, 4'h0);
    chk("cnt0_ready", {3'b0, rdy1}, 4'h1);
    chk("cnt0_sh", sh1, 4'h1);

    send(1'b0, 4'h0);
    send(1'b1, 4'd10);
    repeat (3) @(negedge clk);
    chk("mid_sh_before", sh1, 4'h3);
    cl = 1'b1;
    @(negedge clk);
    cl = 1'b0;
    chk("mid_rst_sh", sh1, 4'h0);
    chk("mid_rst_valid", {3'b0, v1}, 4'h0);
    chk("mid_rst_ready", {3'b0, rdy1}, 4'h1);
    send(1'b0, 4'h9);
    chk("post_rst_j", j1, 4'h9);
    chk("post_rst_k", k1, 4'h0);

    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      cl        = ($urandom_range(0, 60) == 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op    = 1'($urandom);
      cmd_data  = (cmd_op && $urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 4)) : 4'($urandom);
    end
    @(negedge clk);
    cl = 1'b0; cmd_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_excite_gen.md
# jk_excite_gen

Command-driven excitation generator for a bank of W master-slave JK flip-flops. It accepts "load value" and "count N steps" commands over a valid/ready handshake. It emits per-bit J/K drive vectors, one cycle at a time, so the downstream JK bank follows the requested state sequence. It keeps a shadow copy of the bank state and shares the bank's clear. It sits directly upstream of the JK register bank.

## Interface
Parameters:
- W, 4, width of the driven JK bank, shadow and command data (2..16).
- MIN_EXC, 1, load excitation policy:
  - 1: minimal, only bits that change are driven.
  - 0: forced, every bit is explicitly set or reset.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- cl  in  1  reset, synchronous, active-high; also clears the downstream bank.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on an edge where cmd_valid && cmd_ready.
- cmd_op  in  1  0 = LOAD, 1 = COUNT.
- cmd_data  in  W  LOAD: target value; COUNT: step count N (0..2^W-1).
- j  out  W  J drive vector, registered.
- k  out  W  K drive vector, registered.
- jk_valid  out  1  j/k are to be applied by the bank at the end of this cycle.
- busy  out  1  equals !cmd_ready.
- shadow  out  W  modelled bank state after all emitted commands have been applied.

## Operation
- Reset (cl=1 at an edge):
  - state=IDLE, shadow=0, j=0, k=0, jk_valid=0, cmd_ready=1, busy=0.
  - cmd_valid is ignored on any edge where cl=1.
- FSM states: IDLE, LOAD, COUNT.
- IDLE:
  - cmd_ready=1.
  - On accept with cmd_op=0, latch target and go to LOAD.
  - On accept with cmd_op=1 and N>0, latch N and go to COUNT.
  - On accept with cmd_op=1 and N=0, stay in IDLE. No output is produced and cmd_ready stays 1.
- LOAD lasts exactly one cycle, with jk_valid=1:
  - MIN_EXC=1: j = target & ~shadow, k = ~target & shadow.
  - MIN_EXC=0: j = target, k = ~target.
  - At the end of this cycle, shadow <= target and the FSM returns to IDLE.
- COUNT lasts N consecutive cycles, with jk_valid=1 on each:
  - j = k = shadow ^ (shadow+1), computed mod 2^W (toggle mask).
  - shadow <= shadow+1 each cycle, and a remaining-step counter decrements.
  - Wrap-around: shadow=2^W-1 gives mask all-ones and shadow becomes 0.
  - After the Nth cycle, return to IDLE.
- Whenever jk_valid=0, j=0 and k=0, so the bank holds. J=K=1 is never emitted during LOAD.
- Widths: the step counter is W bits. All shadow arithmetic is mod 2^W with no carry out.
- Reset mid-operation:
  - Aborts LOAD or COUNT immediately. Outputs take reset values on the next cycle.
  - The remaining steps are discarded.

## Timing
- Command accepted at edge E:
  - First jk_valid cycle is the cycle after E (one-cycle latency).
  - cmd_ready=0 from the cycle after E.
- LOAD: cmd_ready returns to 1 in the cycle after the single jk_valid cycle. Maximum rate is one LOAD per 2 cycles.
- COUNT N: jk_valid stays high for exactly N cycles with no gaps. cmd_ready returns to 1 in the cycle after the last one.
- shadow updates on the same edge that the bank samples j/k. It therefore always equals the bank Q when the bank shares clk and cl.
- cmd_data and cmd_op are sampled only on the accept edge. Later changes while busy have no effect.

## Test plan
- Reset: assert cl for 2 cycles with cmd_valid=1 and cmd_op=0, cmd_data=4'hF.
  - Required: shadow=0, jk_valid=0, j=k=0, cmd_ready=1.
  - No command is accepted.
- LOAD, W=4, MIN_EXC=1:
  - From shadow=4'b0011, LOAD 4'b0101 → one cycle of j=0100, k=0010; then shadow=0101.
  - LOAD 0101 again → one cycle of j=0000, k=0000.
- LOAD, MIN_EXC=0: from shadow=0011, LOAD 0101 → j=0101, k=1010; shadow=0101.
- COUNT 3 from shadow=4'hE:
  - jk_valid for 3 cycles with masks 0001, 1111, 0001.
  - shadow sequence E→F→0→1.
  - cmd_ready stays low for 3 cycles.
- COUNT 0: accepted, no jk_valid pulse, cmd_ready never drops, shadow unchanged.
- Reset mid-COUNT: COUNT 10 from 0, assert cl on the 4th jk_valid cycle.
  - Required: next cycle shadow=0, jk_valid=0, cmd_ready=1.
  - A new LOAD 4'h9 is then accepted and produces j=1001, k=0000.
